// File: rtl/sram_rr_arbiter.sv
// Two-master round-robin arbiter/sequencer for a single-port 2048x32 SRAM.
// Define SRAM_ARB_STATS_EN to add saturating read/write/conflict counters.
module sram_rr_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_valid_i,
  output logic              m0_req_ready_o,
  input  logic              m0_req_we_i,
  input  logic [ADDR_W-1:0] m0_req_addr_i,
  input  logic [DATA_W-1:0] m0_req_wdata_i,
  output logic              m0_resp_valid_o,
  output logic [DATA_W-1:0] m0_resp_rdata_o,
  input  logic              m1_req_valid_i,
  output logic              m1_req_ready_o,
  input  logic              m1_req_we_i,
  input  logic [ADDR_W-1:0] m1_req_addr_i,
  input  logic [DATA_W-1:0] m1_req_wdata_i,
  output logic              m1_resp_valid_o,
  output logic [DATA_W-1:0] m1_resp_rdata_o,
  output logic              sram_we_o,
  output logic              sram_oe_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_din_o,
  input  logic [DATA_W-1:0] sram_dout_i
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_rd_cnt_o,
  output logic [15:0]       stat_wr_cnt_o,
  output logic [15:0]       stat_conflict_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_CAP  = 2'd2
  } state_e;

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                last_grant_q;
  logic                rd_owner_q;
  logic                sram_we_q, sram_oe_q;
  logic [ADDR_W-1:0]   sram_addr_q;
  logic [DATA_W-1:0]   sram_din_q;
  logic                m0_resp_valid_q, m1_resp_valid_q;
  logic [DATA_W-1:0]   m0_resp_rdata_q, m1_resp_rdata_q;

  logic                gnt0_s, gnt1_s, hs_s, hs_we_s, both_s;
  logic [ADDR_W-1:0]   hs_addr_s;
  logic [DATA_W-1:0]   hs_wdata_s;

  // Grant selection: only in IDLE; on conflict the master that did not win last time goes.
  always_comb begin
    gnt0_s     = 1'b0;
    gnt1_s     = 1'b0;
    both_s     = m0_req_valid_i & m1_req_valid_i;
    if (state_q == IDLE) begin
      if (both_s) begin
        gnt0_s = last_grant_q;
        gnt1_s = ~last_grant_q;
      end else begin
        gnt0_s = m0_req_valid_i;
        gnt1_s = m1_req_valid_i;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
    hs_s       = gnt0_s | gnt1_s;
    hs_we_s    = gnt1_s ? m1_req_we_i    : m0_req_we_i;
    hs_addr_s  = gnt1_s ? m1_req_addr_i  : m0_req_addr_i;
    hs_wdata_s = gnt1_s ? m1_req_wdata_i : m0_req_wdata_i;
  end

  // Read sequencing: wait RD_LAT cycles after issue, then capture for one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (hs_s && !hs_we_s) begin
          state_d = RD_WAIT;
          cnt_d   = LAT_INIT;
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = RD_CAP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RD_CAP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, SRAM command registers and response capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      cnt_q           <= 2'd0;
      last_grant_q    <= 1'b1;
      rd_owner_q      <= 1'b0;
      sram_we_q       <= 1'b0;
      sram_oe_q       <= 1'b0;
      sram_addr_q     <= '0;
      sram_din_q      <= '0;
      m0_resp_valid_q <= 1'b0;
      m1_resp_valid_q <= 1'b0;
      m0_resp_rdata_q <= '0;
      m1_resp_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sram_we_q <= hs_s & hs_we_s;
      sram_oe_q <= hs_s & ~hs_we_s;
      if (hs_s) begin
        last_grant_q <= gnt1_s;
        sram_addr_q  <= hs_addr_s;
        sram_din_q   <= hs_wdata_s;
        if (!hs_we_s) begin
          rd_owner_q <= gnt1_s;
        end
      end
      m0_resp_valid_q <= (state_q == RD_CAP) && !rd_owner_q;
      m1_resp_valid_q <= (state_q == RD_CAP) &&  rd_owner_q;
      if ((state_q == RD_CAP) && !rd_owner_q) begin
        m0_resp_rdata_q <= sram_dout_i;
      end
      if ((state_q == RD_CAP) && rd_owner_q) begin
        m1_resp_rdata_q <= sram_dout_i;
      end
    end
  end

  assign m0_req_ready_o  = gnt0_s;
  assign m1_req_ready_o  = gnt1_s;
  assign sram_we_o       = sram_we_q;
  assign sram_oe_o       = sram_oe_q;
  assign sram_addr_o     = sram_addr_q;
  assign sram_din_o      = sram_din_q;
  assign m0_resp_valid_o = m0_resp_valid_q;
  assign m1_resp_valid_o = m1_resp_valid_q;
  assign m0_resp_rdata_o = m0_resp_rdata_q;
  assign m1_resp_rdata_o = m1_resp_rdata_q;

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q, conflict_cnt_q;

  // Saturating activity counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_q       <= 16'd0;
      wr_cnt_q       <= 16'd0;
      conflict_cnt_q <= 16'd0;
    end else begin
      if (hs_s && !hs_we_s && (rd_cnt_q != 16'hFFFF)) begin
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
      if (hs_s && hs_we_s && (wr_cnt_q != 16'hFFFF)) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
      if ((state_q == IDLE) && both_s && (conflict_cnt_q != 16'hFFFF)) begin
        conflict_cnt_q <= conflict_cnt_q + 16'd1;
      end
    end
  end

  assign stat_rd_cnt_o       = rd_cnt_q;
  assign stat_wr_cnt_o       = wr_cnt_q;
  assign stat_conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed self-checking bench for sram_rr_arbiter with a behavioural RD_LAT=1 SRAM.
module tb_sram_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_valid, m0_req_ready, m0_req_we;
  logic [10:0] m0_req_addr;
  logic [31:0] m0_req_wdata;
  logic        m0_resp_valid;
  logic [31:0] m0_resp_rdata;
  logic        m1_req_valid, m1_req_ready, m1_req_we;
  logic [10:0] m1_req_addr;
  logic [31:0] m1_req_wdata;
  logic        m1_resp_valid;
  logic [31:0] m1_resp_rdata;
  logic        sram_we, sram_oe;
  logic [10:0] sram_addr;
  logic [31:0] sram_din, sram_dout;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0] stat_rd_cnt, stat_wr_cnt, stat_conflict_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_rr_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_valid_i(m0_req_valid), .m0_req_ready_o(m0_req_ready), .m0_req_we_i(m0_req_we),
    .m0_req_addr_i(m0_req_addr), .m0_req_wdata_i(m0_req_wdata),
    .m0_resp_valid_o(m0_resp_valid), .m0_resp_rdata_o(m0_resp_rdata),
    .m1_req_valid_i(m1_req_valid), .m1_req_ready_o(m1_req_ready), .m1_req_we_i(m1_req_we),
    .m1_req_addr_i(m1_req_addr), .m1_req_wdata_i(m1_req_wdata),
    .m1_resp_valid_o(m1_resp_valid), .m1_resp_rdata_o(m1_resp_rdata),
    .sram_we_o(sram_we), .sram_oe_o(sram_oe), .sram_addr_o(sram_addr),
    .sram_din_o(sram_din), .sram_dout_i(sram_dout)
`ifdef SRAM_ARB_STATS_EN
    ,
    .stat_rd_cnt_o(stat_rd_cnt), .stat_wr_cnt_o(stat_wr_cnt),
    .stat_conflict_cnt_o(stat_conflict_cnt)
`endif
  );

  // SRAM model: write at the edge, read data valid one cycle after the oe sample edge.
  logic [31:0] mem [0:2047];
  logic [31:0] dout_q;
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_din;
    if (sram_oe) dout_q <= mem[sram_addr];
  end
  assign sram_dout = dout_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lfsr32(input logic [31:0] x);
    return (x >> 1) ^ ({32{x[0]}} & 32'h80200003);
  endfunction

  function automatic logic [10:0] lfsr11(input logic [10:0] x);
    return (x >> 1) ^ ({11{x[0]}} & 11'h500);
  endfunction

  logic [31:0] pdata [0:7];
  logic [10:0] paddr [0:7];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] s32;
    logic [10:0] s11;
    int i0, i1;
    rst = 1'b1;
    m0_req_valid = 1'b0; m0_req_we = 1'b0; m0_req_addr = 11'd0; m0_req_wdata = 32'd0;
    m1_req_valid = 1'b0; m1_req_we = 1'b0; m1_req_addr = 11'd0; m1_req_wdata = 32'd0;
    s32 = 32'hABCDE123;
    s11 = 11'h5A3;
    for (int j = 0; j < 8; j++) begin
      s32 = lfsr32(s32);
      s11 = lfsr11(s11);
      pdata[j] = s32;
      paddr[j] = {s11[7:0], 3'(j)};
    end
    repeat (3) tick();
    chk("rst_we", sram_we, 32'd0);
    chk("rst_oe", sram_oe, 32'd0);
    chk("rst_addr", sram_addr, 32'd0);
    chk("rst_din", sram_din, 32'd0);
    chk("rst_rv0", m0_resp_valid, 32'd0);
    chk("rst_rv1", m1_resp_valid, 32'd0);
    chk("rst_rd0", m0_resp_rdata, 32'd0);
    chk("rst_rd1", m1_resp_rdata, 32'd0);
    rst = 1'b0;

    // back-to-back writes from m0 then m1
    m0_req_valid = 1'b1; m0_req_we = 1'b1; m0_req_addr = 11'd0; m0_req_wdata = 32'hAAAAAAAA;
    #1;
    chk("wr0_rdy0", m0_req_ready, 32'd1);
    chk("wr0_rdy1", m1_req_ready, 32'd0);
    tick();
    m0_req_valid = 1'b0;
    m1_req_valid = 1'b1; m1_req_we = 1'b1; m1_req_addr = 11'd2047; m1_req_wdata = 32'h55555555;
    #1;
    chk("wr1_rdy1", m1_req_ready, 32'd1);
    chk("wr0_we", sram_we, 32'd1);
    chk("wr0_addr", sram_addr, 32'd0);
    chk("wr0_din", sram_din, 32'hAAAAAAAA);
    tick();
    m1_req_valid = 1'b0;
    #1;
    chk("wr1_we", sram_we, 32'd1);
    chk("wr1_oe", sram_oe, 32'd0);
    chk("wr1_addr", sram_addr, 32'd2047);
    chk("wr1_din", sram_din, 32'h55555555);
    tick();
    chk("wr_end_we", sram_we, 32'd0);
    chk("wr_rv0", m0_resp_valid, 32'd0);
    chk("wr_rv1", m1_resp_valid, 32'd0);

    // m0 single read of addr 0, both masters pressing while busy
    m0_req_valid = 1'b1; m0_req_we = 1'b0; m0_req_addr = 11'd0;
    #1;
    chk("rd_rdy0", m0_req_ready, 32'd1);
    tick();
    m1_req_valid = 1'b1; m1_req_we = 1'b0; m1_req_addr = 11'd5;
    #1;
    chk("rd_t1_oe", sram_oe, 32'd1);
    chk("rd_t1_addr", sram_addr, 32'd0);
    chk("rd_t1_rdy0", m0_req_ready, 32'd0);
    chk("rd_t1_rdy1", m1_req_ready, 32'd0);
    chk("rd_t1_rv0", m0_resp_valid, 32'd0);
    tick();
    chk("rd_t2_oe", sram_oe, 32'd0);
    chk("rd_t2_rdy0", m0_req_ready, 32'd0);
    chk("rd_t2_rdy1", m1_req_ready, 32'd0);
    chk("rd_t2_rv0", m0_resp_valid, 32'd0);
    tick();
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    chk("rd_t3_rv0", m0_resp_valid, 32'd1);
    chk("rd_t3_rd0", m0_resp_rdata, 32'hAAAAAAAA);
    chk("rd_t3_rv1", m1_resp_valid, 32'd0);
    tick();
    chk("rd_t4_rv0", m0_resp_valid, 32'd0);
    chk("rd_t4_hold", m0_resp_rdata, 32'hAAAAAAAA);

    // read-after-write across masters
    m1_req_valid = 1'b1; m1_req_we = 1'b1; m1_req_addr = 11'h3FF; m1_req_wdata = 32'h12345678;
    #1;
    chk("raw_rdy1", m1_req_ready, 32'd1);
    tick();
    m1_req_valid = 1'b0;
    m0_req_valid = 1'b1; m0_req_we = 1'b0; m0_req_addr = 11'h3FF;
    #1;
    chk("raw_rdy0", m0_req_ready, 32'd1);
    tick();
    m0_req_valid = 1'b0;
    repeat (2) tick();
    chk("raw_rv0", m0_resp_valid, 32'd1);
    chk("raw_rd0", m0_resp_rdata, 32'h12345678);
    chk("raw_rv1", m1_resp_valid, 32'd0);
    tick();

    // reset in the cycle after a read handshake
    m0_req_valid = 1'b1; m0_req_we = 1'b0; m0_req_addr = 11'd2047;
    #1;
    chk("mr_rdy0", m0_req_ready, 32'd1);
    tick();
    m0_req_valid = 1'b0;
    rst = 1'b1;
    chk("mr_oe_pre", sram_oe, 32'd1);
    tick();
    rst = 1'b0;
    chk("mr_oe_post", sram_oe, 32'd0);
    chk("mr_rd0", m0_resp_rdata, 32'd0);
    for (int j = 0; j < 4; j++) begin
      chk("mr_rv0", m0_resp_valid, 32'd0);
      chk("mr_rv1", m1_resp_valid, 32'd0);
      tick();
    end
    m0_req_valid = 1'b1; m1_req_valid = 1'b1; m0_req_we = 1'b0; m1_req_we = 1'b0;
    #1;
    chk("mr_first_rdy0", m0_req_ready, 32'd1);
    chk("mr_first_rdy1", m1_req_ready, 32'd0);
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    tick();

    // preload via sustained m1 writes
    for (int j = 0; j < 8; j++) begin
      m1_req_valid = 1'b1; m1_req_we = 1'b1; m1_req_addr = paddr[j]; m1_req_wdata = pdata[j];
      #1;
      chk("pre_rdy1", m1_req_ready, 32'd1);
      tick();
    end
    m1_req_valid = 1'b0;
    tick();

    // continuous contention: grants alternate m0,m1,...
    i0 = 0; i1 = 0;
    m0_req_we = 1'b0; m1_req_we = 1'b0;
    for (int k = 0; k < 6; k++) begin
      m0_req_valid = 1'b1; m0_req_addr = paddr[2*i0];
      m1_req_valid = 1'b1; m1_req_addr = paddr[2*i1+1];
      #1;
      chk("alt_rdy0", m0_req_ready, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("alt_rdy1", m1_req_ready, (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k > 0) begin
        chk("alt_rv0", m0_resp_valid, ((k - 1) % 2 == 0) ? 32'd1 : 32'd0);
        chk("alt_rv1", m1_resp_valid, ((k - 1) % 2 == 1) ? 32'd1 : 32'd0);
        if ((k - 1) % 2 == 0) chk("alt_rd0", m0_resp_rdata, pdata[k-1]);
        else                  chk("alt_rd1", m1_resp_rdata, pdata[k-1]);
      end
      tick();
      if (k % 2 == 0) i0++;
      else            i1++;
      chk("alt_oe", sram_oe, 32'd1);
      chk("alt_addr", sram_addr, paddr[k]);
      chk("alt_busy", m0_req_ready | m1_req_ready, 32'd0);
      tick();
      chk("alt_busy2", m0_req_ready | m1_req_ready, 32'd0);
      tick();
    end
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    #1;
    chk("alt_last_rv1", m1_resp_valid, 32'd1);
    chk("alt_last_rd1", m1_resp_rdata, pdata[5]);
    chk("alt_last_rv0", m0_resp_valid, 32'd0);
    chk("alt_hold_rd0", m0_resp_rdata, pdata[4]);
    tick();

`ifdef SRAM_ARB_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("st_rst_wr", stat_wr_cnt, 32'd0);
    for (int j = 0; j < 3; j++) begin
      m0_req_valid = 1'b1; m0_req_we = 1'b1; m0_req_addr = 11'd100;
      m1_req_valid = 1'b1; m1_req_we = 1'b1; m1_req_addr = 11'd101;
      tick();
    end
    m0_req_we = 1'b0; m1_req_we = 1'b0;
    tick();
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    repeat (2) tick();
    m0_req_valid = 1'b1;
    tick();
    m0_req_valid = 1'b0;
    #1;
    chk("st_wr", stat_wr_cnt, 32'd3);
    chk("st_rd", stat_rd_cnt, 32'd2);
    chk("st_conflict", stat_conflict_cnt, 32'd4);
    repeat (4) tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
